// File: rtl/uart_tx_pkg.sv
// Shared types and frame constants for the byte-wide UART transmitter.
// BYTE_UART_TX_PARITY_EN adds an even-parity bit between data and stop.
package uart_tx_pkg;

    localparam int DATA_BITS        = 8;
    localparam int FRAME_BITS_NOPAR = DATA_BITS + 2;
    localparam int FRAME_BITS_PAR   = DATA_BITS + 3;

`ifdef BYTE_UART_TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PAR;
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;
`else
    localparam int FRAME_BITS = FRAME_BITS_NOPAR;
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
`endif

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-time counter: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
// A synchronous clear holds it at zero so every state starts a fresh bit time.
module baud_tick_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
        end else if (clr || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/byte_uart_tx.sv
// 8N1 UART transmitter pulling bytes from the 16-to-8 FIFO read port.
// Define BYTE_UART_TX_PARITY_EN for an 8E1 frame (even parity bit).
module byte_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_en,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       byte_req,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t     state;
    state_t     state_nxt;
    logic       tick;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;
`ifdef BYTE_UART_TX_PARITY_EN
    logic       par_bit;
`endif

    // Counter is parked while idle or fetching so START begins at zero
    baud_tick_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk  (clk),
        .rstn (rstn),
        .clr  ((state == IDLE) || (state == FETCH)),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (byte_req) state_nxt = FETCH;
            FETCH:  state_nxt = START;
            START:  if (tick) state_nxt = DATA;
`ifdef BYTE_UART_TX_PARITY_EN
            DATA:   if (tick && (bit_idx == LAST_BIT)) state_nxt = PARITY;
            PARITY: if (tick) state_nxt = STOP;
`else
            DATA:   if (tick && (bit_idx == LAST_BIT)) state_nxt = STOP;
`endif
            STOP:   if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_req   = (state == IDLE) && tx_en && byte_valid;
        busy       = (state != IDLE);
        frame_done = (state == STOP) && tick;
    end

    // Line driver and shifter: tx is loaded one cycle ahead of each bit period
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx        <= 1'b1;
            shift_reg <= '0;
            bit_idx   <= '0;
`ifdef BYTE_UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: tx <= 1'b1;
                FETCH: begin
                    shift_reg <= byte_in;
                    bit_idx   <= '0;
                    tx        <= 1'b0;
`ifdef BYTE_UART_TX_PARITY_EN
                    par_bit   <= even_parity(byte_in);
`endif
                end
                START: if (tick) tx <= shift_reg[0];
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef BYTE_UART_TX_PARITY_EN
                            tx <= par_bit;
`else
                            tx <= 1'b1;
`endif
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef BYTE_UART_TX_PARITY_EN
                PARITY: if (tick) tx <= 1'b1;
`endif
                STOP: tx <= 1'b1;
                default: tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_uart_tx.sv
// Directed and randomized bench for byte_uart_tx against a frame-level model.
`timescale 1ns/1ps
module tb_byte_uart_tx;
    import uart_tx_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int LAST_T  = 1 + FRAME_BITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       rstn;
    logic       tx_en;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       byte_req;
    logic       tx;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    byte_uart_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tx_en      (tx_en),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .byte_req   (byte_req),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0]            fifo_q[$];
    logic                  in_frame;
    int                    t;
    logic [FRAME_BITS-1:0] frame_bits;
    int                    cyc;
    int                    req_cycles[$];
    int                    last_done_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line image of one frame, bit 0 first: start, data LSB first, [parity], stop
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] b);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef BYTE_UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        f[FRAME_BITS-1] = 1'b1;
        return f;
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        byte_valid = 1'b1;
    endtask

    task automatic step_cycle();
        logic       exp_req;
        logic       exp_tx;
        logic [7:0] cur;
        @(negedge clk);
        exp_req = !in_frame && tx_en && (fifo_q.size() != 0);
        exp_tx  = (!in_frame || t == 1) ? 1'b1 : frame_bits[(t - 2) / CLK_DIV];
        check("byte_req", byte_req, exp_req);
        check("busy", busy, in_frame);
        check("tx", tx, exp_tx);
        check("frame_done", frame_done, in_frame && (t == LAST_T));
        if (frame_done === 1'b1) last_done_t = in_frame ? t : -1;
        @(posedge clk);
        #1;
        cyc++;
        byte_in = 8'($urandom);
        if (in_frame) begin
            t++;
            if (t > LAST_T) in_frame = 1'b0;
        end
        if (exp_req) begin
            cur        = fifo_q.pop_front();
            in_frame   = 1'b1;
            t          = 1;
            frame_bits = build_frame(cur);
            byte_in    = cur;
            req_cycles.push_back(cyc);
        end
        byte_valid = (fifo_q.size() != 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic run_until_t(input int target);
        for (int i = 0; i < 4000 && !(in_frame && t == target); i++) step_cycle();
        check("reach_frame_offset", in_frame && (t == target), 1);
    endtask

    task automatic run_until_idle();
        for (int i = 0; i < 4000 && in_frame; i++) step_cycle();
        check("reach_idle", in_frame, 0);
    endtask

    initial begin
        rstn = 1'b0; tx_en = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
        in_frame = 1'b0; t = 0; cyc = 0; last_done_t = -1; frame_bits = '1;

        // Reset with tx_en high and nothing queued
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_byte_req", byte_req, 0);
        check("rst_frame_done", frame_done, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        run(8);

        // Single frame 0xA5
        push(8'hA5);
        last_done_t = -1;
        run(LAST_T + 3);
        check("a5_frame_len", last_done_t, LAST_T);

        // Back-to-back 0x00 then 0xFF
        push(8'h00);
        push(8'hFF);
        run(2 * (LAST_T + 1) + 3);
        check("b2b_req_gap", req_cycles[req_cycles.size()-1] - req_cycles[req_cycles.size()-2], LAST_T + 1);

        // Drop tx_en during data bit 3 with a second byte waiting
        push(8'h5A);
        push(8'hC3);
        run_until_t(2 + 4 * CLK_DIV + 1);
        tx_en = 1'b0;
        run_until_idle();
        run(2 * LAST_T);

        // Reset during data bit 5 of the pending byte
        tx_en = 1'b1;
        run_until_t(2 + 6 * CLK_DIV + 1);
        rstn = 1'b0;
        tx_en = 1'b0;
        in_frame = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_byte_req", byte_req, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_tx_held", tx, 1);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        tx_en = 1'b1;
        push(8'h3C);
        last_done_t = -1;
        run(LAST_T + 3);
        check("post_rst_frame_len", last_done_t, LAST_T);

        // 0x07: odd number of ones, parity bit 1 when enabled
        push(8'h07);
        last_done_t = -1;
        run(LAST_T + 3);
        check("b07_frame_len", last_done_t, LAST_T);

        // Randomized bytes, queue arrivals and tx_en gating
        for (int i = 0; i < 6; i++) push(8'($urandom));
        for (int i = 0; i < 500; i++) begin
            tx_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) push(8'($urandom));
            step_cycle();
        end
        tx_en = 1'b1;
        for (int i = 0; i < 4000 && (fifo_q.size() != 0 || in_frame); i++) step_cycle();
        check("drain_done", (fifo_q.size() != 0) || in_frame, 0);
        run(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
